clk_period_meter: RTL and testbench



---
 rtl/clk_meter_pkg.sv | 9 +
 rtl/sync_edge_detect.sv | 25 ++
 rtl/clk_period_meter.sv | 85 ++++++++
 tb/tb_clk_period_meter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg: FSM state type and default parameters for clk_period_meter
package clk_meter_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RUN, TOUT} meter_state_t;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TOL         = 1;
  localparam int DEF_LOCK_COUNT  = 4;
  localparam int DEF_TIMEOUT     = 1000;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer with rise/fall strobes (clk_in, rst, sig_in -> sync, rise, fall)
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sr;
  logic                   last;
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      sr   <= '0;
      last <= 1'b0;
    end else begin
      sr   <= {sr[SYNC_STAGES-2:0], sig_in};
      last <= sr[SYNC_STAGES-1];
    end
  assign sync = sr[SYNC_STAGES-1];
  assign rise = sync & ~last;
  assign fall = ~sync & last;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period/high time of slow sig_in in clk_in cycles, with lock and loss-of-signal (clk_in, rst, sig_in -> period_out, high_out, period_valid, locked, timeout)
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  logic [CNT_W-1:0] cnt, high_cnt, prev, diff;
  logic [MW-1:0]    mcnt, mcnt_d;
  logic             rise, fall, sync_unused, report, tout_go, match;
  meter_state_t     state_q, state_d;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in(clk_in),
    .rst   (rst),
    .sig_in(sig_in),
    .sync  (sync_unused),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk_in or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  // rise always wins over timeout, so a period of exactly TIMEOUT is still reported
  always_comb begin
    state_d = state_q;
    report  = 1'b0;
    tout_go = 1'b0;
    if (state_q == ARMED || state_q == RUN) begin
      report  = rise;
      tout_go = !rise && cnt == CNT_W'(TIMEOUT);
    end
    if (report)       state_d = RUN;
    else if (tout_go) state_d = TOUT;
    else if (rise)    state_d = ARMED;
  end

  assign diff   = cnt > prev ? cnt - prev : prev - cnt;
  assign match  = diff <= CNT_W'(TOL);
  // the first period after ARMED has no valid predecessor, so it never matches
  assign mcnt_d = (state_q == RUN && match) ? (mcnt == MW'(LOCK_COUNT) ? mcnt : mcnt + 1'b1) : '0;

  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      cnt          <= '0;
      high_cnt     <= '0;
      prev         <= '0;
      mcnt         <= '0;
      period_out   <= '0;
      high_out     <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      cnt          <= rise ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);
      period_valid <= report;
      timeout      <= state_d == TOUT;
      if (fall) high_cnt <= cnt;
      if (report) begin
        period_out <= cnt;
        high_out   <= high_cnt;
        prev       <= cnt;
        mcnt       <= mcnt_d;
        locked     <= mcnt_d == MW'(LOCK_COUNT);
      end else if (tout_go) begin
        mcnt   <= '0;
        locked <= 1'b0;
      end
    end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed table plus corner-case sequences for clk_period_meter
module tb_clk_period_meter;
  logic        clk_in = 1'b0;
  logic        rst    = 1'b1;
  logic        sig_in = 1'b0;
  logic [15:0] period_out, high_out;
  logic        period_valid, locked, timeout;

  clk_period_meter dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .sig_in      (sig_in),
    .period_out  (period_out),
    .high_out    (high_out),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {int per; int hi; int lck; int cyc;} rec_t;
  typedef struct {int per; int hi; int lck;} vec_t;

  rec_t q[$];
  int   cyc = 0;
  bit   tout_seen = 0;
  int   n = 0;
  int   fails = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (period_valid) q.push_back('{int'(period_out), int'(high_out), int'(locked), cyc});
    if (timeout) tout_seen = 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // starts #1 after a rising clock edge and ends at the same phase
  task automatic drive(input int per, input int hi);
    sig_in = 1'b1;
    repeat (hi) begin @(posedge clk_in); #1; end
    sig_in = 1'b0;
    repeat (per - hi) begin @(posedge clk_in); #1; end
  endtask

  task automatic do_reset(input bit check);
    sig_in = 1'b0;
    @(posedge clk_in);
    #2 rst = 1'b1;
    #1;
    if (check) begin
      chk("rst_period_out", int'(period_out), 0);
      chk("rst_high_out", int'(high_out), 0);
      chk("rst_valid", int'(period_valid), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_timeout", int'(timeout), 0);
    end
    repeat (2) @(posedge clk_in);
    #1 rst = 1'b0;
    tout_seen = 0;
  endtask

  vec_t tbl[15];
  int   base, tcyc, lcyc;
  bit   got;

  initial begin
    tbl[0]  = '{10, 5, 0};
    tbl[1]  = '{10, 5, 0};
    tbl[2]  = '{10, 5, 0};
    tbl[3]  = '{10, 5, 0};
    tbl[4]  = '{10, 5, 1};
    tbl[5]  = '{11, 5, 1};
    tbl[6]  = '{10, 5, 1};
    tbl[7]  = '{11, 6, 1};
    tbl[8]  = '{14, 7, 0};
    tbl[9]  = '{14, 7, 0};
    tbl[10] = '{14, 7, 0};
    tbl[11] = '{14, 7, 0};
    tbl[12] = '{14, 7, 1};
    tbl[13] = '{7, 1, 0};
    tbl[14] = '{7, 1, 0};

    #3;
    chk("init_period_out", int'(period_out), 0);
    chk("init_locked", int'(locked), 0);
    chk("init_timeout", int'(timeout), 0);
    repeat (2) @(posedge clk_in);
    #1 rst = 1'b0;

    base = q.size();
    foreach (tbl[i]) drive(tbl[i].per, tbl[i].hi);
    drive(4, 1);
    chk("tbl_count", q.size() - base, 15);
    for (int i = 0; i < 15; i++) begin
      if (base + i < q.size()) begin
        chk($sformatf("tbl%0d_period", i), q[base+i].per, tbl[i].per);
        chk($sformatf("tbl%0d_high", i), q[base+i].hi, tbl[i].hi);
        chk($sformatf("tbl%0d_locked", i), q[base+i].lck, tbl[i].lck);
        if (i > 0) chk($sformatf("tbl%0d_spacing", i), q[base+i].cyc - q[base+i-1].cyc, tbl[i].per);
      end
    end
    chk("tbl_no_timeout", int'(tout_seen), 0);

    do_reset(0);
    base = q.size();
    repeat (7) drive(10, 5);
    chk("los_valids", q.size() - base, 6);
    chk("los_locked_before", int'(locked), 1);
    lcyc = q.size() > 0 ? q[$].cyc : 0;
    got = 0;
    tcyc = 0;
    for (int i = 0; i < 1100 && !got; i++) begin
      @(negedge clk_in);
      if (timeout) begin got = 1; tcyc = cyc; end
    end
    chk("los_timeout_seen", int'(got), 1);
    chk("los_timeout_delay", tcyc - lcyc, 1000);
    chk("los_locked_after", int'(locked), 0);
    chk("los_no_valid", q.size() - base, 6);
    @(posedge clk_in);
    #1;
    drive(10, 5);
    chk("restart_timeout_clr", int'(timeout), 0);
    chk("restart_no_valid", q.size() - base, 6);
    drive(10, 5);
    chk("restart_valid", q.size() - base, 7);
    chk("restart_period", int'(period_out), 10);
    chk("restart_high", int'(high_out), 5);
    chk("restart_locked", int'(locked), 0);

    sig_in = 1'b1;
    repeat (3) begin @(posedge clk_in); #1; end
    do_reset(1);
    base = q.size();
    drive(8, 4);
    chk("rstmid_first_rise", q.size() - base, 0);
    drive(8, 4);
    chk("rstmid_second_rise", q.size() - base, 1);
    chk("rstmid_period", int'(period_out), 8);
    chk("rstmid_high", int'(high_out), 4);

    do_reset(0);
    base = q.size();
    drive(1000, 500);
    drive(4, 1);
    chk("bound_valid", q.size() - base, 1);
    chk("bound_period", int'(period_out), 1000);
    chk("bound_high", int'(high_out), 500);
    chk("bound_timeout", int'(tout_seen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
